// File: rtl/traffic_light_pkg.sv
// Shared types and lamp encodings for the highway/farm-road traffic light.
//   state_e      : 2-bit controller state
//   LIGHT_*      : one-hot lamp codes {red,yellow,green}
package traffic_light_pkg;

  localparam int unsigned LIGHT_W = 3;

  typedef enum logic [1:0] {
    HGRE_FRED = 2'd0,
    HYEL_FRED = 2'd1,
    HRED_FGRE = 2'd2,
    HRED_FYEL = 2'd3
  } state_e;

  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;

endpackage

// File: rtl/traffic_light.sv
// Four-state Moore traffic-light controller for a highway/farm-road crossing.
// Highway rests in green; a farm-road vehicle (sensor) starts the sequence
// highway yellow -> farm green -> farm yellow -> highway green.
// Ports:
//   light_highway : highway lamp, one-hot {red,yellow,green}
//   light_farm    : farm-road lamp, same encoding
//   sensor        : farm-road vehicle present, sampled on clk rising edge
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES     = 3,
  parameter int unsigned FARM_GREEN_CYCLES = 10,
  parameter int unsigned HWY_MIN_GREEN     = 1
) (
  output logic [LIGHT_W-1:0] light_highway,
  output logic [LIGHT_W-1:0] light_farm,
  input  logic               sensor,
  input  logic               clk,
  input  logic               rst_n
);

  localparam int unsigned MAX_A = (YELLOW_CYCLES > FARM_GREEN_CYCLES) ?
                                  YELLOW_CYCLES : FARM_GREEN_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > HWY_MIN_GREEN) ? MAX_A : HWY_MIN_GREEN;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] FG_LAST  = CNT_W'(FARM_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HMG_LAST = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // State register and dwell counter; the counter clears on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HGRE_FRED;
      cnt   <= '0;
    end else begin
      case (state)
        HGRE_FRED: begin
          if (sensor && (cnt >= HMG_LAST)) begin
            state <= HYEL_FRED;
            cnt   <= '0;
          end else if (cnt < HMG_LAST) begin
            // Saturate so an idle highway never wraps the counter.
            cnt <= cnt + CNT_ONE;
          end
        end
        HYEL_FRED: begin
          if (cnt == Y_LAST) begin
            state <= HRED_FGRE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HRED_FGRE: begin
          if (cnt == FG_LAST) begin
            state <= HRED_FYEL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HRED_FYEL: begin
          if (cnt == Y_LAST) begin
            state <= HGRE_FRED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= HGRE_FRED;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    light_highway = LIGHT_GREEN;
    light_farm    = LIGHT_RED;
    case (state)
      HGRE_FRED: begin
        light_highway = LIGHT_GREEN;
        light_farm    = LIGHT_RED;
      end
      HYEL_FRED: begin
        light_highway = LIGHT_YELLOW;
        light_farm    = LIGHT_RED;
      end
      HRED_FGRE: begin
        light_highway = LIGHT_RED;
        light_farm    = LIGHT_GREEN;
      end
      HRED_FYEL: begin
        light_highway = LIGHT_RED;
        light_farm    = LIGHT_YELLOW;
      end
      default: begin
        light_highway = LIGHT_GREEN;
        light_farm    = LIGHT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: a default instance and an overridden
// instance (Y=2, FG=5, MIN=4) share stimulus; a countdown reference model
// pushes expected lamps per edge and the sampled outputs are popped against it.
module tb_traffic_light;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic [2:0] hwy_a, farm_a, hwy_b, farm_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  logic [5:0] seen_a, seen_b;

  // Reference model state: 0 HG, 1 HY, 2 FG, 3 FY.
  int m_st[2]   = '{0, 0};
  int m_left[2] = '{0, 0};
  int m_hg[2]   = '{1, 1};
  int p_y[2]    = '{3, 2};
  int p_fg[2]   = '{10, 5};
  int p_min[2]  = '{1, 4};

  traffic_light dut_a (
    .light_highway(hwy_a),
    .light_farm   (farm_a),
    .sensor       (sensor),
    .clk          (clk),
    .rst_n        (rst_n)
  );

  traffic_light #(
    .YELLOW_CYCLES    (2),
    .FARM_GREEN_CYCLES(5),
    .HWY_MIN_GREEN    (4)
  ) dut_b (
    .light_highway(hwy_b),
    .light_farm   (farm_b),
    .sensor       (sensor),
    .clk          (clk),
    .rst_n        (rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] mlight(input int st);
    case (st)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      2:       return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction

  // Advance model i by one rising edge with the given inputs.
  task automatic mstep(input int i, input bit s, input bit r);
    if (!r) begin
      m_st[i] = 0;
      m_hg[i] = 1;
    end else begin
      case (m_st[i])
        0: begin
          if (s && m_hg[i] >= p_min[i]) begin
            m_st[i] = 1;
            m_left[i] = p_y[i];
          end else if (m_hg[i] < 1000) begin
            m_hg[i]++;
          end
        end
        1: if (m_left[i] == 1) begin m_st[i] = 2; m_left[i] = p_fg[i]; end
           else m_left[i]--;
        2: if (m_left[i] == 1) begin m_st[i] = 3; m_left[i] = p_y[i]; end
           else m_left[i]--;
        default: if (m_left[i] == 1) begin m_st[i] = 0; m_hg[i] = 1; end
                 else m_left[i]--;
      endcase
    end
  endtask

  function automatic logic safe(input logic [2:0] h, input logic [2:0] f);
    return ($countones(h) == 1) && ($countones(f) == 1) &&
           ((h == 3'b100) || (f == 3'b100));
  endfunction

  // One clock: drive inputs, predict, then sample #1 after the edge and compare.
  task automatic tick(input bit s, input bit r);
    logic [5:0] exp_a, exp_b;
    sensor = s;
    rst_n  = r;
    mstep(0, s, r);
    q_a.push_back(mlight(m_st[0]));
    mstep(1, s, r);
    q_b.push_back(mlight(m_st[1]));
    @(posedge clk);
    #1;
    seen_a = {hwy_a, farm_a};
    seen_b = {hwy_b, farm_b};
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp_a = q_a.pop_front();
      exp_b = q_b.pop_front();
      check("lamps_a", 32'(seen_a), 32'(exp_a));
      check("lamps_b", 32'(seen_b), 32'(exp_b));
    end
    check("safe_a", 32'(safe(hwy_a, farm_a)), 32'd1);
    check("safe_b", 32'(safe(hwy_b, farm_b)), 32'd1);
  endtask

  initial begin
    int nfg_a, nfg_b, nfy_a, nhy_a;

    // Reset and idle: highway green throughout.
    tick(0, 0);
    tick(0, 0);
    check("rst_a", 32'(seen_a), 32'h0C);
    check("rst_b", 32'(seen_b), 32'h0C);
    for (int i = 0; i < 30; i++) tick(0, 1);
    check("idle_a", 32'(seen_a), 32'h0C);

    // Single one-cycle request, then quiet.
    tick(1, 1);
    check("req_hy_a", 32'(seen_a), 32'h14);
    for (int i = 0; i < 22; i++) tick(0, 1);
    check("req_done_a", 32'(seen_a), 32'h0C);

    // Sensor held high from reset: count farm-green cycles over 34 edges.
    nfg_a = 0; nfg_b = 0;
    tick(1, 0);
    for (int i = 0; i < 33; i++) begin
      tick(1, 1);
      if (seen_a[2:0] == 3'b001) nfg_a++;
      if (seen_b[2:0] == 3'b001) nfg_b++;
    end
    check("held_fg_a", 32'(nfg_a), 32'd20);
    check("held_fg_b", 32'(nfg_b), 32'd12);

    // Sensor dropped during farm green: full farm green and yellow remain.
    nfg_a = 0; nfy_a = 0;
    tick(0, 0);
    for (int i = 0; i < 30; i++) begin
      tick(i < 5, 1);
      if (seen_a[2:0] == 3'b001) nfg_a++;
      if (seen_a[2:0] == 3'b010) nfy_a++;
    end
    check("drop_fg_a", 32'(nfg_a), 32'd10);
    check("drop_fy_a", 32'(nfy_a), 32'd3);

    // Reset at the 5th farm-green cycle, then a fresh request.
    tick(1, 1);
    for (int i = 0; i < 7; i++) tick(0, 1);
    check("mid_fg_a", 32'(seen_a), 32'h21);
    tick(0, 0);
    check("mid_rst_a", 32'(seen_a), 32'h0C);
    for (int i = 0; i < 5; i++) tick(0, 1);
    nhy_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i == 0, 1);
      if (seen_a[5:3] == 3'b010) nhy_a++;
    end
    check("mid_hy_len_a", 32'(nhy_a), 32'd3);

    // Random sensor traffic with occasional resets.
    for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 2) != 0), $urandom_range(0, 40) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
Four-state Moore controller for a highway/farm-road intersection.
- Highway holds green by default.
- A farm-road vehicle sensor requests a sequence: highway yellow, farm green, farm yellow, then back to highway green.
- Dwell times are counted in clock cycles of the single system clock. There is no internal clock divider; the integrator scales the parameters to the clock rate.

Parameters:
- YELLOW_CYCLES, 3, cycles spent in each yellow state (>=1).
- FARM_GREEN_CYCLES, 10, cycles farm road stays green (>=1).
- HWY_MIN_GREEN, 1, minimum cycles in highway-green before the sensor is honoured (>=1).

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- sensor  input  1  farm-road vehicle present, level-sensitive, sampled on clk rising edge.
- light_highway  output  3  highway lamp, one-hot {red,yellow,green}: 3'b001 green, 3'b010 yellow, 3'b100 red.
- light_farm  output  3  farm-road lamp, same encoding.

Positional port order is fixed as: light_highway, light_farm, sensor, clk, rst_n.

Behaviour:
- States and outputs (highway / farm):
  - HGRE_FRED = 001/100
  - HYEL_FRED = 010/100
  - HRED_FGRE = 100/001
  - HRED_FYEL = 100/010
- Outputs are decoded combinationally from the registered state only (pure Moore). They never depend on sensor directly.
- Reset: a rising clk edge with rst_n=0 sets state=HGRE_FRED and dwell counter=0. Outputs therefore become 001/100 immediately after that edge. Before the first reset edge the outputs are X.
- Reset has priority over every transition, in any state, mid-dwell.
- Dwell counter:
  - Cleared to 0 on every state change.
  - Increments each cycle while in a timed state.
  - In HGRE_FRED it saturates at HWY_MIN_GREEN-1.
  - Width is $clog2 of the largest parameter, plus 1.
- HGRE_FRED -> HYEL_FRED: at a rising edge where sensor=1 and counter >= HWY_MIN_GREEN-1. Otherwise the state holds indefinitely.
- HYEL_FRED -> HRED_FGRE: when counter == YELLOW_CYCLES-1, so highway yellow is visible for exactly YELLOW_CYCLES cycles.
- HRED_FGRE -> HRED_FYEL: when counter == FARM_GREEN_CYCLES-1. Duration is fixed; the sensor value is ignored.
- HRED_FYEL -> HGRE_FRED: when counter == YELLOW_CYCLES-1.
- Sensor changes outside HGRE_FRED are ignored. No request is latched: a sensor pulse that falls between edges, or arrives during another state, is lost.
- With sensor held at 1, the sequence repeats with period HWY_MIN_GREEN + 2*YELLOW_CYCLES + FARM_GREEN_CYCLES (17 cycles at defaults).
- Safety invariants, holding every cycle after reset:
  - Never both lights non-red simultaneously.
  - Each output is always exactly one-hot.
- Illegal or unreachable state encodings recover to HGRE_FRED on the next edge.

Decomposition:
- Package traffic_light_pkg holds:
  - the state enum (2-bit: HGRE_FRED, HYEL_FRED, HRED_FGRE, HRED_FYEL);
  - the lamp constants LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b100.
- Single module containing the state register, dwell counter, next-state logic and output decode. No sub-module is warranted.

Test Plan:
- Reset/idle: rst_n=0 for 2 edges, sensor=0, then rst_n=1 for 30 cycles -> outputs 001/100 throughout; no transitions.
- Single request: sensor=1 sampled at edge k, then sensor=0 -> outputs are:
  - 010/100 for edges k..k+2;
  - 100/001 for edges k+3..k+12;
  - 100/010 for edges k+13..k+15;
  - 001/100 from edge k+16 onward.
- Sensor held high: sensor=1 continuously after reset -> the sequence repeats with a 17-cycle period. Highway green lasts 1 cycle per period. Both-non-red is never observed.
- Sensor drop during farm green: sensor=1 to trigger, then sensor=0 at the 2nd farm-green cycle -> farm green still lasts the full 10 cycles, followed by 3 yellow cycles.
- Reset mid-operation: rst_n=0 at the 5th cycle of HRED_FGRE -> next edge gives 001/100. A subsequent request shows a full 3-cycle highway yellow, confirming the counter was cleared.
- Parameter override: YELLOW_CYCLES=2, FARM_GREEN_CYCLES=5, HWY_MIN_GREEN=4, reset then sensor=1 continuously -> repeating pattern of:
  - 4 cycles 001/100;
  - 2 cycles 010/100;
  - 5 cycles 100/001;
  - 2 cycles 100/010.
